iq_downconverter: RTL
=====================

// Module: iq_downconverter
// PURPOSE
//  Receive-side counterpart of the NCO->DAC transmit path. Takes offset-binary ADC samples,
//  re-centres them to signed, mixes with the NCO's sin/cos outputs, and integrates-and-dumps
//  over DECIM samples. Emits one I/Q pair per window on a valid/ready output.
//  Sits between the ADC capture register and the symbol/demod logic, in the pll_clock domain.
// PARAMETERS
//  ADC_WIDTH  6   ADC sample width, unsigned offset-binary (mid-scale = 2**(ADC_WIDTH-1))
//  LO_WIDTH   5   NCO sin/cos width, two's complement
//  DECIM      16  samples per integrate-and-dump window, >=2
//  ACC_WIDTH  16  accumulator/output width; must be >= ADC_WIDTH+LO_WIDTH+clog2(DECIM)-1
//  SHIFT      4   right-shift applied to outputs when DDC_ROUND_EN is defined
// PORTS
//  clk        in   1          pll_clock domain clock
//  rst        in   1          synchronous active-high reset
//  clk_en     in   1          sample enable; low = datapath frozen
//  adc_in     in   ADC_WIDTH  unsigned offset-binary sample
//  lo_sin     in   LO_WIDTH   signed NCO sine, time-aligned with adc_in
//  lo_cos     in   LO_WIDTH   signed NCO cosine, time-aligned with adc_in
//  i_out      out  ACC_WIDTH  signed in-phase result
//  q_out      out  ACC_WIDTH  signed quadrature result
//  out_valid  out  1          result held valid until accepted
//  out_ready  in   1          downstream accept
//  overrun    out  1          sticky: a window result was dropped
// BEHAVIOUR
//  - Reset: i_out=0, q_out=0, out_valid=0, overrun=0; pipeline regs, accumulators and sample counter cleared.
//  - rst mid-window discards the partial window; first post-reset sample is window sample 0.
//  - S1 (clk_en): x = adc_in - 2**(ADC_WIDTH-1) (MSB invert), signed ADC_WIDTH; sin/cos registered alongside.
//  - S2 (clk_en): pi = x*cos, pq = x*sin, full-precision signed ADC_WIDTH+LO_WIDTH bits.
//  - S3 (clk_en): cnt counts 0..DECIM-1, wraps. cnt<DECIM-1: acc += p.
//    cnt==DECIM-1 (dump): result = acc+p; acc <= 0 (dumped sample not carried).
//  - Latency: last sample of a window on adc_in at edge t -> out_valid high after edge t+3.
//  - clk_en low: S1-S3 regs, cnt, acc hold; output handshake still operates.
//  - Output: on dump, if !out_valid or out_ready -> load i_out/q_out, out_valid=1.
//    If out_valid && !out_ready -> new result dropped, old result held, overrun<=1 (sticky until rst).
//  - out_valid && out_ready with no dump -> out_valid<=0, i_out/q_out hold last value.
//  - Same-cycle accept + dump: new result loaded, out_valid stays 1, no overrun.
//  - Accumulator never wraps for legal ACC_WIDTH; no saturation logic.
// CONFIGURATION
//  DDC_ROUND_EN defined: i_out/q_out = (result + 2**(SHIFT-1)) >>> SHIFT, round-half-up,
//    sign-extended to ACC_WIDTH; rounding adds no cycle of latency.
//  DDC_ROUND_EN undefined: i_out/q_out = raw result; SHIFT unused.
// TESTING  (defaults, DDC_ROUND_EN undefined unless stated)
//  1 adc_in=32, any LO, 16 enabled cycles -> out_valid after 3-cycle latency, i_out=0, q_out=0.
//  2 adc_in=63, lo_cos=15, lo_sin=-16 held -> i_out=7440, q_out=-7936; with DDC_ROUND_EN: 465, -496.
//  3 adc_in=0, lo_cos=-16, lo_sin=15 -> i_out=8192, q_out=-7680; repeats every 16 enabled cycles.
//  4 out_ready=0 across two windows -> first result held, overrun=1; out_ready=1 then -> first result
//    accepted, next dump loads normally; overrun stays 1 until rst.
//  5 clk_en toggled 1/0 each cycle, case 2 stimulus -> one result per 32 clocks, values unchanged.
//  6 rst pulsed at window sample 7 -> all outputs 0; next result covers 16 post-reset samples exactly.

Source files
------------

// File: rtl/iq_downconverter.sv
// I/Q downconverter: offset-binary ADC re-centre, NCO mix, integrate-and-dump over DECIM samples.
// Optional output rounding/shift is enabled by defining DDC_ROUND_EN.
`timescale 1ns/1ps
module iq_downconverter #(
   parameter int ADC_WIDTH = 6,
   parameter int LO_WIDTH  = 5,
   parameter int DECIM     = 16,
   parameter int ACC_WIDTH = 16,
   parameter int SHIFT     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_en,
   input  logic [ADC_WIDTH-1:0]        adc_in,
   input  logic signed [LO_WIDTH-1:0]  lo_sin,
   input  logic signed [LO_WIDTH-1:0]  lo_cos,
   output logic signed [ACC_WIDTH-1:0] i_out,
   output logic signed [ACC_WIDTH-1:0] q_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        overrun
);

   localparam int P_WIDTH   = ADC_WIDTH + LO_WIDTH;
   localparam int CNT_WIDTH = (DECIM > 2) ? $clog2(DECIM) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DECIM - 1);

   if (DECIM < 2 || SHIFT < 1 ||
       ACC_WIDTH < ADC_WIDTH + LO_WIDTH + $clog2(DECIM) - 1) begin : g_bad_cfg
      $error("iq_downconverter: illegal parameter combination");
   end

   logic signed [ADC_WIDTH-1:0] x_s1;
   logic signed [LO_WIDTH-1:0]  sin_s1, cos_s1;
   logic                        v_s1;
   logic signed [P_WIDTH-1:0]   pi_s2, pq_s2;
   logic                        v_s2;
   logic [CNT_WIDTH-1:0]        cnt;
   logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
   logic signed [ACC_WIDTH-1:0] res_i, res_q;
   logic                        dump;
   logic signed [ACC_WIDTH-1:0] fin_i, fin_q;

   // v_s1/v_s2 keep the flushed (zero) pipeline from counting as window samples after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         x_s1   <= '0;
         sin_s1 <= '0;
         cos_s1 <= '0;
         v_s1   <= 1'b0;
         pi_s2  <= '0;
         pq_s2  <= '0;
         v_s2   <= 1'b0;
         cnt    <= '0;
         acc_i  <= '0;
         acc_q  <= '0;
         res_i  <= '0;
         res_q  <= '0;
         dump   <= 1'b0;
      end else begin
         dump <= 1'b0;
         if (clk_en) begin
            x_s1   <= {~adc_in[ADC_WIDTH-1], adc_in[ADC_WIDTH-2:0]};
            sin_s1 <= lo_sin;
            cos_s1 <= lo_cos;
            v_s1   <= 1'b1;
            pi_s2  <= P_WIDTH'(x_s1) * P_WIDTH'(cos_s1);
            pq_s2  <= P_WIDTH'(x_s1) * P_WIDTH'(sin_s1);
            v_s2   <= v_s1;
            if (v_s2) begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  acc_i <= '0;
                  acc_q <= '0;
                  res_i <= acc_i + ACC_WIDTH'(pi_s2);
                  res_q <= acc_q + ACC_WIDTH'(pq_s2);
                  dump  <= 1'b1;
               end else begin
                  cnt   <= cnt + CNT_WIDTH'(1);
                  acc_i <= acc_i + ACC_WIDTH'(pi_s2);
                  acc_q <= acc_q + ACC_WIDTH'(pq_s2);
               end
            end
         end
      end
   end

`ifdef DDC_ROUND_EN
   localparam int HALF = 2 ** (SHIFT - 1);
   always_comb begin
      fin_i = (res_i + ACC_WIDTH'(HALF)) >>> SHIFT;
      fin_q = (res_q + ACC_WIDTH'(HALF)) >>> SHIFT;
   end
`else
   always_comb begin
      fin_i = res_i;
      fin_q = res_q;
   end
`endif

   // output handshake runs every clock, independent of clk_en
   always_ff @(posedge clk) begin
      if (rst) begin
         i_out     <= '0;
         q_out     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (dump) begin
         if (!out_valid || out_ready) begin
            i_out     <= fin_i;
            q_out     <= fin_q;
            out_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
